ps2_scancode_receiver: RTL and testbench

PS2_SCANCODE_RECEIVER -- requirements
Module: ps2_scancode_receiver

---
 rtl/ps2_scancode_receiver.sv | 183 ++++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard scan-code receiver.
// Synchronizes the raw PS/2 clock and data pins and deframes 11-bit frames: start bit,
// 8 data bits (LSB first), odd parity and stop bit. The 0xF0 (break) and 0xE0 (extended)
// prefixes are folded into flags that go out with the next ordinary code.
// A frame that stalls for TIMEOUT system clocks is abandoned and reported as a frame error.
//
// Ports:
//   clk_i           system clock (25 MHz pixel clock); all state changes on its rising edge
//   rst_ni          asynchronous active-low reset
//   ps2_clk_i       raw PS/2 clock, asynchronous to clk_i; receive only
//   ps2_data_i      raw PS/2 data, asynchronous to clk_i; receive only
//   scan_code_o     last accepted non-prefix scan code; holds until the next scan_valid_o
//   scan_valid_o    one-cycle pulse; scan_code_o, break_o and extended_o are valid in it
//   break_o         reported code was preceded by 0xF0
//   extended_o      reported code was preceded by 0xE0
//   parity_error_o  one-cycle pulse on a parity failure
//   frame_error_o   one-cycle pulse on a bad stop bit or a timeout
module ps2_scancode_receiver #(
   parameter int unsigned TIMEOUT     = 2500,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] scan_code_o,
   output logic       scan_valid_o,
   output logic       break_o,
   output logic       extended_o,
   output logic       parity_error_o,
   output logic       frame_error_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
   logic                   clk_prev_q;
   logic                   ps2_clk_s, ps2_data_s, fall_edge, timeout_hit;

   state_e            state_q, state_d;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              parity_q, parity_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              pend_brk_q, pend_brk_d;
   logic              pend_ext_q, pend_ext_d;
   logic [7:0]        code_q, code_d;
   logic              brk_q, brk_d;
   logic              ext_q, ext_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;

   assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
   assign fall_edge  = clk_prev_q & ~ps2_clk_s;

   // Counter holds cycles elapsed since the last edge; it fires on the cycle it would reach
   // TIMEOUT. An edge in the same cycle keeps the frame alive.
   assign timeout_hit = (state_q != StIdle) && !fall_edge && (cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         clk_prev_q  <= 1'b0;
         state_q     <= StIdle;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         parity_q    <= 1'b0;
         cnt_q       <= '0;
         pend_brk_q  <= 1'b0;
         pend_ext_q  <= 1'b0;
         code_q      <= '0;
         brk_q       <= 1'b0;
         ext_q       <= 1'b0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev_q  <= ps2_clk_s;
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         parity_q    <= parity_d;
         cnt_q       <= cnt_d;
         pend_brk_q  <= pend_brk_d;
         pend_ext_q  <= pend_ext_d;
         code_q      <= code_d;
         brk_q       <= brk_d;
         ext_q       <= ext_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      parity_d   = parity_q;
      pend_brk_d = pend_brk_q;
      pend_ext_d = pend_ext_q;
      code_d     = code_q;
      brk_d      = brk_q;
      ext_d      = ext_q;
      valid_d    = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;

      if (state_q == StIdle || fall_edge) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end

      if (timeout_hit) begin
         state_d    = StIdle;
         cnt_d      = '0;
         ferr_d     = 1'b1;
         pend_brk_d = 1'b0;
         pend_ext_d = 1'b0;
      end else if (fall_edge) begin
         unique case (state_q)
            StIdle: begin
               // A high level here is line noise, not a start bit.
               if (!ps2_data_s) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end
            end
            StData: begin
               shift_d   = {ps2_data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StParity;
               end
            end
            StParity: begin
               parity_d = ps2_data_s;
               state_d  = StStop;
            end
            StStop: begin
               state_d = StIdle;
               // Stop-bit failure outranks a parity failure.
               if (!ps2_data_s) begin
                  ferr_d     = 1'b1;
                  pend_brk_d = 1'b0;
                  pend_ext_d = 1'b0;
               end else if (!(^{shift_q, parity_q})) begin
                  perr_d     = 1'b1;
                  pend_brk_d = 1'b0;
                  pend_ext_d = 1'b0;
               end else if (shift_q == 8'hF0) begin
                  pend_brk_d = 1'b1;
               end else if (shift_q == 8'hE0) begin
                  pend_ext_d = 1'b1;
               end else begin
                  code_d     = shift_q;
                  brk_d      = pend_brk_q;
                  ext_d      = pend_ext_q;
                  valid_d    = 1'b1;
                  pend_brk_d = 1'b0;
                  pend_ext_d = 1'b0;
               end
            end
         endcase
      end
   end

   assign scan_code_o    = code_q;
   assign scan_valid_o   = valid_q;
   assign break_o        = brk_q;
   assign extended_o     = ext_q;
   assign parity_error_o = perr_q;
   assign frame_error_o  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver. Frames are driven on the raw PS/2 pins; at each
// stop bit (or abandoned frame) the expected outcome and its due cycle are queued, and every
// cycle the outputs are checked against the queue and against the held-value model.
module tb_ps2_scancode_receiver;

   localparam int unsigned TIMEOUT     = 200;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int          HALF        = 8;
   localparam int          KValid      = 0;
   localparam int          KParity     = 1;
   localparam int          KFrame      = 2;

   typedef struct {
      int         kind;
      logic [7:0] code;
      logic       brk;
      logic       ext;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] scan_code;
   logic       scan_valid, brk_o, ext_o, perr, ferr;

   exp_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   logic [7:0] m_code = 8'h00;
   logic       m_brk = 1'b0;
   logic       m_ext = 1'b0;
   logic       m_pend_brk = 1'b0;
   logic       m_pend_ext = 1'b0;

   ps2_scancode_receiver #(
      .TIMEOUT     (TIMEOUT),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .ps2_clk_i      (ps2_clk),
      .ps2_data_i     (ps2_data),
      .scan_code_o    (scan_code),
      .scan_valid_o   (scan_valid),
      .break_o        (brk_o),
      .extended_o     (ext_o),
      .parity_error_o (perr),
      .frame_error_o  (ferr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      int   kind;
      chk("one_pulse_max", $countones({scan_valid, perr, ferr}) <= 1, 1);
      if (scan_valid || perr || ferr) begin
         kind = scan_valid ? KValid : (perr ? KParity : KFrame);
         chk("pulse_expected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_cycle", cyc, e.due);
            if (e.kind == KValid) begin
               m_code = e.code;
               m_brk  = e.brk;
               m_ext  = e.ext;
            end
         end
      end
      // Outside a valid pulse the code and flags must hold; in it they must be the new ones.
      chk("scan_code", scan_code, m_code);
      chk("break", brk_o, m_brk);
      chk("extended", ext_o, m_ext);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) tick();
   endtask

   // Output registers lag a raw pin change by the synchronizer depth plus one cycle.
   task automatic send_bit(input logic b, output int fall_cyc);
      ps2_data = b;
      wait_ticks(HALF);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_ticks(HALF);
      ps2_clk  = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop);
      logic par;
      int   f;
      exp_t e;
      par = ~(^code) ^ bad_par;
      send_bit(1'b0, f);
      for (int i = 0; i < 8; i++) send_bit(code[i], f);
      send_bit(par, f);
      ps2_data = stop;
      wait_ticks(HALF);
      ps2_clk = 1'b0;
      e.due   = cyc + SYNC_STAGES + 1;
      e.code  = code;
      e.brk   = m_pend_brk;
      e.ext   = m_pend_ext;
      if (!stop) begin
         e.kind = KFrame;
         sb.push_back(e);
         m_pend_brk = 1'b0;
         m_pend_ext = 1'b0;
      end else if (bad_par) begin
         e.kind = KParity;
         sb.push_back(e);
         m_pend_brk = 1'b0;
         m_pend_ext = 1'b0;
      end else if (code == 8'hF0) begin
         m_pend_brk = 1'b1;
      end else if (code == 8'hE0) begin
         m_pend_ext = 1'b1;
      end else begin
         e.kind = KValid;
         sb.push_back(e);
         m_pend_brk = 1'b0;
         m_pend_ext = 1'b0;
      end
      wait_ticks(HALF);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_ticks(2 * HALF);
   endtask

   initial begin
      int   f;
      exp_t e;
      logic [7:0] partial;
      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_ticks(4);
      rst_n = 1'b1;
      wait_ticks(2 * HALF);

      // V1: plain code
      send_frame(8'h1D, 1'b0, 1'b1);
      // A clock pulse with data high in idle is ignored.
      send_bit(1'b1, f);
      wait_ticks(2 * HALF);
      // V2: break prefix applies once
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1D, 1'b0, 1'b1);
      send_frame(8'h1D, 1'b0, 1'b1);
      // V3: both prefixes
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      // V4: parity error, stop error, both wrong (frame error wins)
      send_frame(8'h29, 1'b1, 1'b1);
      send_frame(8'h1D, 1'b0, 1'b0);
      send_frame(8'h1D, 1'b1, 1'b0);
      // An error drops a pending break.
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h29, 1'b1, 1'b1);
      send_frame(8'h1D, 1'b0, 1'b1);

      // V5: abandoned frame after start + 4 data bits; pending break is dropped too
      send_frame(8'hF0, 1'b0, 1'b1);
      partial = 8'h1D;
      send_bit(1'b0, f);
      for (int i = 0; i < 4; i++) send_bit(partial[i], f);
      e.kind = KFrame;
      e.code = 8'h00;
      e.brk  = 1'b0;
      e.ext  = 1'b0;
      e.due  = f + int'(TIMEOUT) + SYNC_STAGES + 1;
      sb.push_back(e);
      m_pend_brk = 1'b0;
      m_pend_ext = 1'b0;
      wait_ticks(int'(TIMEOUT) + 4 * HALF);
      chk("timeout_drained", sb.size(), 0);
      send_frame(8'h1C, 1'b0, 1'b1);

      // V6: reset after the 5th bit of a frame clears outputs at once, without a clock edge
      partial = 8'h23;
      send_bit(1'b0, f);
      for (int i = 0; i < 4; i++) send_bit(partial[i], f);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_scan_code", scan_code, 8'h00);
      chk("rst_flags", {scan_valid, brk_o, ext_o, perr, ferr}, 5'b0);
      m_code = 8'h00;
      m_brk  = 1'b0;
      m_ext  = 1'b0;
      m_pend_brk = 1'b0;
      m_pend_ext = 1'b0;
      wait_ticks(HALF);
      rst_n = 1'b1;
      wait_ticks(int'(TIMEOUT) + 2 * HALF);
      send_frame(8'h23, 1'b0, 1'b1);

      wait_ticks(4 * HALF);
      chk("queue_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
